hazard_stall_controller: RTL and testbench

Pipeline sequencing controller for the 5-stage RV32 core. It sits beside the forwarding unit and covers the hazards forwarding cannot resolve: load-use, taken-branch/jump redirect and multi-cycle MDU operations in EX. It drives the PC and pipeline-register write-enable and flush controls. It also keeps saturating stall and flush performance counters.

---
 rtl/hazard_stall_controller.sv | 145 ++++++++++++++
 tb/tb_hazard_stall_controller.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: load-use stalls, redirect flushes and MDU holds
// for the 5-stage core, plus saturating stall/flush performance counters.
module hazard_stall_controller #(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_Rs1,
    input  logic [4:0]       IF_ID_Rs2,
    input  logic             ID_uses_rs1,
    input  logic             ID_uses_rs2,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_Rd,
    input  logic             EX_redirect,
    input  logic             EX_mdu_start,
    input  logic             mdu_done,
    input  logic             perf_clr,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Write,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic             mdu_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [1:0]       fsm_state
);

    localparam int TW = $clog2(MDU_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_INIT     = 2'd0,
        S_RUN      = 2'd1,
        S_MDU_WAIT = 2'd2
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          lu;
    logic          release_mdu;
    logic          timed_out;
    logic          stall_inc;
    logic          flush_inc;

    assign fsm_state = state;

    assign lu = ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
                ((ID_uses_rs1 && (ID_EX_Rd == IF_ID_Rs1)) ||
                 (ID_uses_rs2 && (ID_EX_Rd == IF_ID_Rs2)));

    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Write  = 1'b1;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        release_mdu  = 1'b0;
        timed_out    = 1'b0;
        case (state)
            S_RUN: begin
                if (EX_redirect) begin
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                end else if (EX_mdu_start) begin
                    PC_Write     = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EX_Write  = 1'b0;
                    EX_MEM_Flush = 1'b1;
                end else if (lu) begin
                    // ID/EX stays enabled so the bubble is actually loaded
                    PC_Write    = 1'b0;
                    IF_ID_Write = 1'b0;
                    ID_EX_Flush = 1'b1;
                end
            end
            S_MDU_WAIT: begin
                if (mdu_done) begin
                    release_mdu = 1'b1;
                end else if (timer == TW'(MDU_TIMEOUT - 1)) begin
                    release_mdu = 1'b1;
                    timed_out   = 1'b1;
                end else begin
                    PC_Write     = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EX_Write  = 1'b0;
                    EX_MEM_Flush = 1'b1;
                end
            end
            default: begin
                PC_Write     = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Write  = 1'b0;
                IF_ID_Flush  = 1'b1;
                ID_EX_Flush  = 1'b1;
                EX_MEM_Flush = 1'b1;
            end
        endcase
    end

    assign stall_inc = (state != S_INIT) && !PC_Write;
    assign flush_inc = (state == S_RUN) && EX_redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_INIT;
            timer       <= '0;
            mdu_timeout <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (!EX_redirect && EX_mdu_start) begin
                        state <= S_MDU_WAIT;
                        timer <= '0;
                    end
                end
                S_MDU_WAIT: begin
                    if (release_mdu) state <= S_RUN;
                    else             timer <= timer + TW'(1);
                    if (timed_out)   mdu_timeout <= 1'b1;
                end
                default: state <= S_RUN;
            endcase
        end
    end

    // Clear wins over a same-cycle increment; both counters stick at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else if (perf_clr) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_inc && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (flush_inc && (flush_events != {CNT_W{1'b1}}))
                flush_events <= flush_events + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed-vector bench for hazard_stall_controller (MDU_TIMEOUT=8, CNT_W=4):
// the driver queues each cycle's expected outputs, a negedge monitor compares.
module tb_hazard_stall_controller;

    localparam int CW = 4;
    localparam int VW = 2 + 6 + 1 + CW + CW;

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Flush}
    localparam logic [5:0] C_NORM = 6'b110100;
    localparam logic [5:0] C_INIT = 6'b001011;
    localparam logic [5:0] C_LU   = 6'b000110;
    localparam logic [5:0] C_RED  = 6'b111110;
    localparam logic [5:0] C_HOLD = 6'b000001;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] rs1, rs2, rd;
    logic u1, u2, mr, redir, start, done, clr;
    logic pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_f, to;
    logic [CW-1:0] sc, fe;
    logic [1:0] st;

    logic [VW-1:0] exp_q[$];
    string         name_q[$];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_stall_controller #(.MDU_TIMEOUT(8), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_Rs1(rs1), .IF_ID_Rs2(rs2),
        .ID_uses_rs1(u1), .ID_uses_rs2(u2),
        .ID_EX_MemRead(mr), .ID_EX_Rd(rd),
        .EX_redirect(redir), .EX_mdu_start(start),
        .mdu_done(done), .perf_clr(clr),
        .PC_Write(pc_w), .IF_ID_Write(ifid_w), .IF_ID_Flush(ifid_f),
        .ID_EX_Write(idex_w), .ID_EX_Flush(idex_f), .EX_MEM_Flush(exmem_f),
        .mdu_timeout(to), .stall_cycles(sc), .flush_events(fe),
        .fsm_state(st)
    );

    // Monitor: every cycle with a queued expectation is compared mid-cycle
    always @(negedge clk) begin
        logic [VW-1:0] act, expv;
        string nm;
        if (exp_q.size() > 0) begin
            expv = exp_q.pop_front();
            nm   = name_q.pop_front();
            act  = {st, pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_f, to, sc, fe};
            checks++;
            if (act !== expv) begin
                failures++;
                $display("FAIL %s: got st=%0d ctl=%b to=%b sc=%0d fe=%0d, want st=%0d ctl=%b to=%b sc=%0d fe=%0d",
                         nm, act[VW-1 -: 2], act[VW-3 -: 6], act[2*CW], act[2*CW-1 -: CW], act[CW-1:0],
                         expv[VW-1 -: 2], expv[VW-3 -: 6], expv[2*CW], expv[2*CW-1 -: CW], expv[CW-1:0]);
            end
        end
    end

    task automatic idle();
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        u1 = 1'b0; u2 = 1'b0; mr = 1'b0;
        redir = 1'b0; start = 1'b0; done = 1'b0; clr = 1'b0;
    endtask

    task automatic load(input logic [4:0] d, input logic [4:0] s1, input logic a1,
                        input logic [4:0] s2, input logic a2);
        mr = 1'b1; rd = d; rs1 = s1; u1 = a1; rs2 = s2; u2 = a2;
    endtask

    // Queue this cycle's expectation, then advance to just after the next edge
    task automatic step(input string nm, input logic [1:0] es, input logic [5:0] ec,
                        input logic eto, input logic [CW-1:0] esc, input logic [CW-1:0] efe);
        exp_q.push_back({es, ec, eto, esc, efe});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        #1;

        step("reset_hold", ST_INIT, C_INIT, 1'b0, 4'd0, 4'd0);
        rst_n = 1'b1;
        step("release_cycle", ST_INIT, C_INIT, 1'b0, 4'd0, 4'd0);
        step("run_normal", ST_RUN, C_NORM, 1'b0, 4'd0, 4'd0);

        load(5'd5, 5'd5, 1'b1, 5'd1, 1'b1);
        step("lu_rs1", ST_RUN, C_LU, 1'b0, 4'd0, 4'd0);
        idle();
        step("after_lu", ST_RUN, C_NORM, 1'b0, 4'd1, 4'd0);
        load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        step("lu_rd_x0", ST_RUN, C_NORM, 1'b0, 4'd1, 4'd0);
        load(5'd7, 5'd7, 1'b0, 5'd3, 1'b1);
        step("lu_rs1_unused", ST_RUN, C_NORM, 1'b0, 4'd1, 4'd0);
        load(5'd7, 5'd2, 1'b1, 5'd7, 1'b1);
        step("lu_rs2", ST_RUN, C_LU, 1'b0, 4'd1, 4'd0);
        idle();
        step("after_lu_rs2", ST_RUN, C_NORM, 1'b0, 4'd2, 4'd0);

        load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        redir = 1'b1;
        step("redirect_lu", ST_RUN, C_RED, 1'b0, 4'd2, 4'd0);
        idle();
        step("after_redirect", ST_RUN, C_NORM, 1'b0, 4'd2, 4'd1);

        clr = 1'b1;
        step("clr_cycle", ST_RUN, C_NORM, 1'b0, 4'd2, 4'd1);
        load(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        clr = 1'b1;
        step("clr_vs_stall", ST_RUN, C_LU, 1'b0, 4'd0, 4'd0);
        idle();
        step("clr_priority", ST_RUN, C_NORM, 1'b0, 4'd0, 4'd0);

        // MDU: start cycle + 5 held wait cycles, released on the done cycle
        start = 1'b1;
        step("mdu_start", ST_RUN, C_HOLD, 1'b0, 4'd0, 4'd0);
        idle();
        for (int i = 0; i < 5; i++) begin
            redir = (i == 2);
            step("mdu_wait", ST_WAIT, C_HOLD, 1'b0, 4'(i + 1), 4'd0);
        end
        idle();
        done = 1'b1;
        step("mdu_done", ST_WAIT, C_NORM, 1'b0, 4'd6, 4'd0);
        step("done_in_run", ST_RUN, C_NORM, 1'b0, 4'd6, 4'd0);
        idle();
        clr = 1'b1;
        step("clr2", ST_RUN, C_NORM, 1'b0, 4'd6, 4'd0);
        idle();

        // Timeout: 8 cycles in MDU_WAIT, the last one releases
        start = 1'b1;
        step("to_start", ST_RUN, C_HOLD, 1'b0, 4'd0, 4'd0);
        idle();
        for (int i = 0; i < 7; i++)
            step("to_wait", ST_WAIT, C_HOLD, 1'b0, 4'(i + 1), 4'd0);
        step("to_release", ST_WAIT, C_NORM, 1'b0, 4'd8, 4'd0);
        clr = 1'b1;
        step("to_flag_set", ST_RUN, C_NORM, 1'b1, 4'd8, 4'd0);
        idle();
        step("to_after_clr", ST_RUN, C_NORM, 1'b1, 4'd0, 4'd0);

        // Saturation: 20 consecutive stall cycles
        load(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 20; i++)
            step("sat_stall", ST_RUN, C_LU, 1'b1, (i > 15) ? 4'd15 : 4'(i), 4'd0);
        idle();
        step("sat_hold", ST_RUN, C_NORM, 1'b1, 4'd15, 4'd0);

        // Reset while waiting on the MDU
        start = 1'b1;
        step("rst_mdu_start", ST_RUN, C_HOLD, 1'b1, 4'd15, 4'd0);
        idle();
        step("rst_mdu_wait", ST_WAIT, C_HOLD, 1'b1, 4'd15, 4'd0);
        rst_n = 1'b0;
        step("rst_mid_mdu", ST_INIT, C_INIT, 1'b0, 4'd0, 4'd0);
        done = 1'b1;
        step("rst_still_low", ST_INIT, C_INIT, 1'b0, 4'd0, 4'd0);
        idle();
        rst_n = 1'b1;
        step("rst_release2", ST_INIT, C_INIT, 1'b0, 4'd0, 4'd0);
        step("rst_run2", ST_RUN, C_NORM, 1'b0, 4'd0, 4'd0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
